des_key_schedule: RTL
=====================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have no parameters; key width 64, subkey width 48 and round count 16 are fixed.
REQ-002 SHALL have a port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have a port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have a port start, input, 1 bit: request to begin a schedule; sampled only in IDLE.
REQ-005 SHALL have a port decrypt, input, 1 bit: sampled with start; 0 selects K1..K16 order, 1 selects K16..K1 order.
REQ-006 SHALL have a port key_in, input, [0:63]: DES key, bit 0 = FIPS bit 1; sampled with start.
REQ-007 SHALL have a port subkey_out, output, [0:47]: current round key, bit 0 = FIPS bit 1.
REQ-008 SHALL have a port subkey_idx, output, [3:0]: round number minus 1 (0..15) of the key on subkey_out.
REQ-009 SHALL have a port subkey_valid, output, 1 bit: subkey_out/subkey_idx hold a valid key.
REQ-010 SHALL have a port subkey_ready, input, 1 bit: consumer accepts the key; a transfer occurs when valid and ready are both high at a rising edge.
REQ-011 SHALL have a port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have a port done, output, 1 bit: one-cycle pulse after the 16th transfer.

Function
REQ-013 SHALL implement states IDLE and GEN; reset enters IDLE.
REQ-014 IDLE -> GEN on a rising edge with start=1; start in GEN is ignored, with no restart and no key/mode resample.
REQ-015 On acceptance, SHALL apply PC-1 to key_in, giving 28-bit C0 and D0; parity bits 8,16,..,64 are ignored.
REQ-016 Encrypt acceptance SHALL load C,D = ROL(C0,1), ROL(D0,1), set idx=0, and register mode.
REQ-017 Decrypt acceptance SHALL load C,D = C0,D0 (equal to C16,D16 since total shift = 28), set idx=15, and register mode.
REQ-018 Shift schedule s(r) for r=1..16 SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-019 subkey_out SHALL be PC-2(C,D), a function of registers only.
REQ-020 subkey_valid SHALL be 1 exactly while in GEN; the first key appears the cycle after acceptance (latency 1).
REQ-021 subkey_out and subkey_idx SHALL hold stable while valid=1 and ready=0; there are no bubbles between transfers.
REQ-022 Encrypt transfer with idx<15 SHALL apply ROL by s(idx+2) to C and D and set idx+1.
REQ-023 Decrypt transfer with idx>0 SHALL apply ROR by s(idx+1) to C and D and set idx-1.
REQ-024 A transfer of the last key (encrypt idx=15, decrypt idx=0) SHALL return the block to IDLE and assert done for the next cycle only.
REQ-025 start high in the same cycle as the last transfer SHALL be ignored; a new schedule may be accepted from the following IDLE cycle.
REQ-026 The decrypt input changing during GEN SHALL have no effect.

Reset
REQ-027 rst_n low SHALL, asynchronously and at any time including mid-schedule, force IDLE, C=D=0, idx=0, subkey_out=0, subkey_valid=0, busy=0 and done=0.
REQ-028 After rst_n rises, the first start SHALL be accepted no earlier than the first rising edge with rst_n high.

Verification
REQ-029 Encrypt, key 133457799BBCDFF1, ready=1 -> 16 consecutive keys; idx 0: 1B02EFFC7072; idx 1: 79AED9DBC9E5; idx 15: CB3D8B0E17F5; done pulse one cycle after the idx-15 transfer.
REQ-030 Decrypt, same key -> first key idx=15 CB3D8B0E17F5; second idx=14; last idx=0 1B02EFFC7072; the full sequence equals the encrypt sequence reversed.
REQ-031 Backpressure: ready held low 5 cycles at idx 3 -> subkey_out/idx stable for those cycles, no skipped or duplicated index, 16 transfers total.
REQ-032 start pulsed with a different key/mode during GEN -> sequence unchanged; start on the last-transfer cycle ignored; start one cycle later accepted.
REQ-033 rst_n asserted at idx 7 -> all outputs 0 immediately without waiting for a clock; a new start yields a correct full schedule.
REQ-034 Keys differing only in parity bits -> identical subkey sequences.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule generator.
// Accepts a 64-bit key, then streams the sixteen 48-bit round keys over a
// valid/ready handshake, in K1..K16 order for encryption or K16..K1 for
// decryption. C and D are rotated in place, so one PC-2 network serves all
// rounds and the output depends only on registered state.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [0:63] key_in,
    output logic [0:47] subkey_out,
    output logic [3:0]  subkey_idx,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Permuted choice 1 (FIPS 1-based bit numbers of key_in): C half, then D half.
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2 (FIPS 1-based bit numbers of the 56-bit C||D).
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Rotate a 28-bit half toward bit 0 (FIPS left) by one or two places.
    function automatic logic [0:27] rot_left(input logic [0:27] x, input logic two);
        return two ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
    endfunction

    // Inverse rotation, used to walk the schedule backwards.
    function automatic logic [0:27] rot_right(input logic [0:27] x, input logic two);
        return two ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
    endfunction

    // Round r (1..16) shifts by one only for r = 1, 2, 9 and 16.
    function automatic logic shift_is_two(input logic [4:0] round);
        return !(round == 5'd1 || round == 5'd2 || round == 5'd9 || round == 5'd16);
    endfunction

    state_t      state_q, state_d;
    logic [0:27] c_q, c_d;
    logic [0:27] d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;

    logic [0:27] c0, d0;
    logic [0:55] cd;
    logic        last_key;

    // PC-1: pure wiring from the key; parity bits are never selected.
    for (genvar i = 0; i < 28; i++) begin : g_pc1
        assign c0[i] = key_in[PC1[i] - 1];
        assign d0[i] = key_in[PC1[i + 28] - 1];
    end

    // PC-2 on the registered halves gives the current round key.
    assign cd = {c_q, d_q};
    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign subkey_out[i] = cd[PC2[i] - 1];
    end

    assign last_key     = dec_q ? (idx_q == 4'd0) : (idx_q == 4'd15);
    assign subkey_idx   = idx_q;
    assign subkey_valid = (state_q == GEN);
    assign busy         = (state_q == GEN);
    assign done         = done_q;

    // Next-state logic: load on start in IDLE, advance one round per transfer in GEN.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = GEN;
                    dec_d   = decrypt;
                    if (decrypt) begin
                        // Total rotation over 16 rounds is 28, so C0/D0 already equal C16/D16.
                        c_d   = c0;
                        d_d   = d0;
                        idx_d = 4'd15;
                    end else begin
                        c_d   = rot_left(c0, 1'b0);
                        d_d   = rot_left(d0, 1'b0);
                        idx_d = 4'd0;
                    end
                end
            end
            GEN: begin
                if (subkey_ready) begin
                    if (last_key) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (dec_q) begin
                        // Undo the shift of the round currently presented (round idx+1).
                        c_d   = rot_right(c_q, shift_is_two({1'b0, idx_q} + 5'd1));
                        d_d   = rot_right(d_q, shift_is_two({1'b0, idx_q} + 5'd1));
                        idx_d = idx_q - 4'd1;
                    end else begin
                        // Apply the shift of the next round (round idx+2).
                        c_d   = rot_left(c_q, shift_is_two({1'b0, idx_q} + 5'd2));
                        d_d   = rot_left(d_q, shift_is_two({1'b0, idx_q} + 5'd2));
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear of every output-visible flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= 4'd0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

endmodule
